// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the sequential restoring divider.
//   DEFAULT_WIDTH : default operand/result width
//   IDLE/RUN/DONE : state encoding, also exposed as the enum state_t
// No ports (package).
// -----------------------------------------------------------------------------
package divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_t;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider_if
// Operand/result bundle of the divider.
//   start       : request, sampled only while the divider is idle
//   dividend    : unsigned dividend, captured with an accepted start
//   divisor     : unsigned divisor, captured with an accepted start
//   busy        : division in progress
//   done        : one-cycle pulse, results valid from this cycle on
//   quotient    : result quotient, held until the next accepted start
//   remainder   : result remainder, held until the next accepted start
//   div_by_zero : divisor was zero, held with the results
// Handshake: start is a request without a ready; it is accepted on a rising
// edge where the divider is idle and start=1, and ignored otherwise. Every
// accepted start produces exactly one done pulse (unless reset intervenes).
// Modports: master = requester, slave = divider.
// -----------------------------------------------------------------------------
interface seq_restoring_divider_if
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder cell.
//   i_a, i_b : addend bits
//   i_ci     : carry in
//   o_s      : sum
//   o_co     : carry out
// -----------------------------------------------------------------------------
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

// File: rtl/trial_subtractor.sv
// -----------------------------------------------------------------------------
// trial_subtractor
// N-bit ripple subtractor a - b, computed as a + ~b + 1 with a chain of
// full_adder cells whose first carry-in is tied high.
//   i_a      : minuend
//   i_b      : subtrahend
//   o_diff   : a - b (modulo 2^N)
//   o_borrow : 1 when b > a (inverted final carry)
// -----------------------------------------------------------------------------
module trial_subtractor #(
  parameter int N = 9
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_diff,
  output logic         o_borrow
);

  logic [N:0] w_carry;

  assign w_carry[0] = 1'b1;

  for (genvar g = 0; g < N; g++) begin : g_fa
    full_adder u_fa (
      .i_a  (i_a[g]),
      .i_b  (~i_b[g]),
      .i_ci (w_carry[g]),
      .o_s  (o_diff[g]),
      .o_co (w_carry[g+1])
    );
  end

  assign o_borrow = ~w_carry[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// seq_restoring_divider
// Sequential unsigned restoring divider, one quotient bit per clock.
// A division accepted at edge E0 iterates at E1..E(WIDTH) and shows done=1
// during the cycle after E(WIDTH); results hold until the next accepted start.
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   bus         : seq_restoring_divider_if.slave (start/operands/results)
//   o_dbg_state : current FSM state (divider_pkg encoding)
// Optional feature macro DIV_ZERO_DETECT_EN: when defined, a zero divisor
// goes straight from IDLE to DONE with quotient=all ones, remainder=dividend
// and div_by_zero=1; when undefined a zero divisor runs the full iteration
// count (same quotient/remainder) and div_by_zero stays 0.
// -----------------------------------------------------------------------------
module seq_restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_restoring_divider_if.slave bus,
  output logic [1:0]             o_dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_divisor;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic [WIDTH:0]   w_p_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic             w_restore;
  logic [WIDTH-1:0] w_p_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_last;
  logic             w_accept;
  logic             w_zero_early;

  // Partial remainder shifted left with the next dividend bit pulled in.
  // The stored remainder is always below the divisor, so its (WIDTH+1)-bit
  // form has a zero MSB and only WIDTH bits are kept in r_p.
  assign w_p_shift = {r_p, r_q[WIDTH-1]};

  trial_subtractor #(
    .N (WIDTH + 1)
  ) u_trial_subtractor (
    .i_a      (w_p_shift),
    .i_b      ({1'b0, r_divisor}),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  // A difference that would not fit in WIDTH bits is treated like a borrow.
  // While the remainder stays below the divisor this never happens, so the
  // decision is the plain borrow.
  assign w_restore = w_borrow | w_diff[WIDTH];
  assign w_p_next  = w_restore ? w_p_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_q_next  = {r_q[WIDTH-2:0], ~w_restore};
  assign w_last    = (r_cnt == CW'(1));

`ifdef DIV_ZERO_DETECT_EN
  assign w_zero_early = (bus.divisor == '0);
`else
  assign w_zero_early = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_state_next = w_zero_early ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand capture, iteration, result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q         <= '0;
      r_p         <= '0;
      r_divisor   <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else if (w_accept) begin
      r_divisor <= bus.divisor;
      r_q       <= bus.dividend;
      r_p       <= '0;
      r_cnt     <= CW'(WIDTH);
      // Early-out result is written on the same edge that enters DONE.
      if (w_zero_early) begin
        r_quotient  <= '1;
        r_remainder <= bus.dividend;
        r_dbz       <= 1'b1;
      end
    end else if (r_state == ST_RUN) begin
      r_p   <= w_p_next;
      r_q   <= w_q_next;
      r_cnt <= r_cnt - CW'(1);
      // Results change only on the edge that enters DONE.
      if (w_last) begin
        r_quotient  <= w_q_next;
        r_remainder <= w_p_next;
        r_dbz       <= 1'b0;
      end
    end
  end

  assign bus.busy        = (r_state == ST_RUN);
  assign bus.done        = (r_state == ST_DONE);
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_dbz;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_restoring_divider
// Self-checking bench for seq_restoring_divider (WIDTH=8). Expected results
// come from plain integer division in a reference function and are queued
// in a scoreboard when each division is issued.
// -----------------------------------------------------------------------------
module tb_seq_restoring_divider;

  localparam int W = 8;
`ifdef DIV_ZERO_DETECT_EN
  localparam logic ZD = 1'b1;
`else
  localparam logic ZD = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  seq_restoring_divider_if #(.WIDTH(W)) bus ();

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  logic [2*W:0] exp_q[$];   // {div_by_zero, remainder, quotient}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    if (ib == 0) return {ZD, a, {W{1'b1}}};
    return {1'b0, W'(ia % ib), W'(ia / ib)};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one start pulse, wait for done, compare against the scoreboard
  // ---------------------------------------------------------------------------
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [2*W:0] e;
    int lat;
    int exp_lat;
    bit got;
    int recon;
    exp_q.push_back(ref_div(a, b));
    exp_lat = (b == '0 && ZD) ? 1 : W + 1;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 4 * W) begin
      @(posedge clk);
      #1;
      lat++;
      bus.start = 1'b0;
      if (lat == 1) check({tag, "_busy_run"}, 32'(bus.busy), 32'(b != '0 || !ZD));
      got = bus.done;
    end
    check({tag, "_done_seen"}, 32'(got), 1);
    check({tag, "_latency"}, lat, exp_lat);
    e = exp_q.pop_front();
    check({tag, "_quot"}, 32'(bus.quotient), 32'(e[W-1:0]));
    check({tag, "_rem"}, 32'(bus.remainder), 32'(e[2*W-1:W]));
    check({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(e[2*W]));
    check({tag, "_busy_done"}, 32'(bus.busy), 0);
    if (b != '0) begin
      recon = int'(bus.quotient) * int'(b) + int'(bus.remainder);
      check({tag, "_ident"}, recon, 32'(a));
      check({tag, "_rem_lt_div"}, 32'(bus.remainder < b), 1);
    end
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(bus.done), 0);
    check({tag, "_quot_hold"}, 32'(bus.quotient), 32'(e[W-1:0]));
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int lat;
    bit got;
    int done_cnt;
    logic [W-1:0] ra, rb;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n        = 1'b0;
    #12;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_quot", 32'(bus.quotient), 0);
    check("rst_rem", 32'(bus.remainder), 0);
    check("rst_dbz", 32'(bus.div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_div(8'd100, 8'd7, "d100_7");
    run_div(8'd255, 8'd1, "d255_1");
    run_div(8'd5, 8'd9, "d5_9");
    run_div(8'd42, 8'd0, "d42_0");
    run_div(8'd0, 8'd3, "d0_3");
    run_div(8'd255, 8'd255, "d255_255");

    // start held high through a whole division with changing operands
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd200;
    bus.divisor  = 8'd13;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 4 * W) begin
      @(posedge clk);
      #1;
      lat++;
      got = bus.done;
      if (!got) begin
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom_range(1, 255));
      end
    end
    check("hold_done_seen", 32'(got), 1);
    check("hold_latency", lat, W + 1);
    check("hold_quot", 32'(bus.quotient), 15);
    check("hold_rem", 32'(bus.remainder), 5);
    bus.dividend = 8'd50;
    bus.divisor  = 8'd6;
    @(posedge clk);
    #1;
    // Still in the DONE->IDLE edge: start is not taken yet.
    check("hold_done_drop", 32'(bus.done), 0);
    check("hold_no_accept_in_done", 32'(bus.busy), 0);
    @(posedge clk);
    #1;
    check("hold_next_accept", 32'(bus.busy), 1);
    bus.start = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 4 * W) begin
      @(posedge clk);
      #1;
      lat++;
      got = bus.done;
    end
    check("hold2_done_seen", 32'(got), 1);
    check("hold2_latency", lat, W);
    check("hold2_quot", 32'(bus.quotient), 8);
    check("hold2_rem", 32'(bus.remainder), 2);
    @(posedge clk);
    #1;

    // Reset during RUN
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 0);
    check("arst_done", 32'(bus.done), 0);
    check("arst_quot", 32'(bus.quotient), 0);
    check("arst_rem", 32'(bus.remainder), 0);
    check("arst_dbz", 32'(bus.div_by_zero), 0);
    check("arst_state", 32'(dbg_state), 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 2 * W; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_cnt++;
    end
    check("arst_no_done", done_cnt, 0);
    run_div(8'd9, 8'd3, "d9_3");

    // Randomized operands
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) rb = '0;
      else if ($urandom_range(0, 1) == 0) rb = W'($urandom_range(1, 15));
      else rb = W'($urandom_range(1, 255));
      run_div(ra, rb, "rand");
    end

    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
